pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the architectural program counter and sequences the fetch address:
//   sequential PC+INC on an accepted fetch, taken-branch redirect (with a
//   one-cycle flush bubble), stall/backpressure hold, and halt.
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_fetch_ready  instruction memory accepts o_pc this cycle
//   i_stall        decode/execute hazard, hold the PC
//   i_redirect     taken branch or jump from execute
//   i_target       redirect target address
//   i_halt         stop fetching (HLT/WFI)
//   o_pc           registered fetch address
//   o_fetch_valid  o_pc is a valid fetch request
//   o_pc_plus4     o_pc + INC, combinational, for the link register
//   o_flush        one-cycle kill of younger in-flight instructions
//   o_fault        one-cycle pulse for a misaligned redirect target
//   o_fetch_cnt    count of accepted fetches (wraps)

module pc_sequencer #(
  parameter int                ADDR_W       = 64,
  parameter int                INC          = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 64'h200,
  parameter int                CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_ready,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fetch_valid,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_flush,
  output logic              o_fault,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_REDIRECT,
    ST_HALT
  } state_t;

  state_t state;
  state_t state_next;

  logic take_redirect;
  logic misaligned;
  logic accept;

  // BOOT ignores every control input; elsewhere redirect has top priority.
  assign take_redirect = i_redirect && (state != ST_BOOT);
  assign misaligned    = (i_target[1:0] != 2'b00);

  // A fetch is only accepted when nothing of higher priority pre-empts it,
  // so a redirect or halt in the same cycle drops the pending fetch.
  assign accept = (state == ST_FETCH) && i_fetch_ready && !i_stall &&
                  !i_halt && !i_redirect;

  assign o_pc_plus4 = o_pc + ADDR_W'(INC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_redirect)  state_next = ST_REDIRECT;
        else if (i_halt) state_next = ST_HALT;
        else             state_next = ST_FETCH;
      end
      ST_REDIRECT: begin
        // A second redirect restarts the bubble so the flush stays high.
        if (i_redirect)  state_next = ST_REDIRECT;
        else if (i_halt) state_next = ST_HALT;
        else             state_next = ST_FETCH;
      end
      ST_HALT: begin
        if (i_redirect) state_next = ST_REDIRECT;
        else            state_next = ST_HALT;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    o_fetch_valid = 1'b0;
    o_flush       = 1'b0;
    case (state)
      ST_FETCH:    o_fetch_valid = 1'b1;
      ST_REDIRECT: o_flush       = 1'b1;
      default: begin
        o_fetch_valid = 1'b0;
        o_flush       = 1'b0;
      end
    endcase
  end

  // A misaligned target is replaced by the exception vector and flagged on
  // the same cycle the redirect bubble is visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc        <= RESET_VECTOR;
      o_fault     <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      o_fault <= take_redirect && misaligned;
      if (take_redirect) begin
        o_pc <= misaligned ? EXC_VECTOR : i_target;
      end else if (accept) begin
        o_pc <= o_pc + ADDR_W'(INC);
      end
      if (accept) begin
        o_fetch_cnt <= o_fetch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer. A behavioural model describes what the
//   fetch unit must present each cycle (boot bubble, halted, flushing, PC and
//   accepted-fetch count); a compare process checks every output against it
//   on each falling edge, and the stimulus process adds literal expectations
//   at the scenario checkpoints.

module tb_pc_sequencer;

  localparam logic [63:0] RESET_VECTOR = 64'h0;
  localparam logic [63:0] EXC_VECTOR   = 64'h200;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic        stall;
  logic        redirect;
  logic [63:0] target;
  logic        halt;
  logic [63:0] pc;
  logic        fetch_valid;
  logic [63:0] pc_plus4;
  logic        flush;
  logic        fault;
  logic [31:0] fetch_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fetch_ready (fetch_ready),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_target      (target),
    .i_halt        (halt),
    .o_pc          (pc),
    .o_fetch_valid (fetch_valid),
    .o_pc_plus4    (pc_plus4),
    .o_flush       (flush),
    .o_fault       (fault),
    .o_fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the fetch unit is doing, not how it is encoded.
  logic        m_booting;
  logic        m_halted;
  logic        m_flushing;
  logic        m_fault;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;

  function automatic logic m_valid();
    return !m_booting && !m_halted && !m_flushing;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_booting  = 1'b1;
      m_halted   = 1'b0;
      m_flushing = 1'b0;
      m_fault    = 1'b0;
      m_pc       = RESET_VECTOR;
      m_cnt      = 32'd0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (redirect) begin
      m_flushing = 1'b1;
      m_halted   = 1'b0;
      m_fault    = (target % 4) != 0;
      m_pc       = m_fault ? EXC_VECTOR : target;
    end else begin
      m_fault = 1'b0;
      if (halt) begin
        m_halted   = 1'b1;
        m_flushing = 1'b0;
      end else begin
        if (m_valid() && fetch_ready && !stall) begin
          m_pc  = m_pc + 64'd4;
          m_cnt = m_cnt + 32'd1;
        end
        m_flushing = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_pc",       pc,                 m_pc);
      checkOutput("model_pc_plus4", pc_plus4,           m_pc + 64'd4);
      checkOutput("model_valid",    {63'd0, fetch_valid}, {63'd0, m_valid()});
      checkOutput("model_flush",    {63'd0, flush},     {63'd0, m_flushing});
      checkOutput("model_fault",    {63'd0, fault},     {63'd0, m_fault});
      checkOutput("model_cnt",      {32'd0, fetch_cnt}, {32'd0, m_cnt});
    end
  end

  // Drive one cycle of inputs, then return at the next falling edge so the
  // outputs reflect the rising edge that consumed them.
  task automatic applyStimulus(input logic rdy, input logic stl, input logic rdr,
                               input logic [63:0] tgt, input logic hlt);
    fetch_ready = rdy;
    stall       = stl;
    redirect    = rdr;
    target      = tgt;
    halt        = hlt;
    @(negedge clk);
  endtask

  task automatic checkLiteral(input string name, input logic [63:0] exp_pc,
                              input logic exp_valid, input logic exp_flush,
                              input logic exp_fault, input logic [31:0] exp_cnt);
    checkOutput({name, "_pc"},    pc,                   exp_pc);
    checkOutput({name, "_valid"}, {63'd0, fetch_valid}, {63'd0, exp_valid});
    checkOutput({name, "_flush"}, {63'd0, flush},       {63'd0, exp_flush});
    checkOutput({name, "_fault"}, {63'd0, fault},       {63'd0, exp_fault});
    checkOutput({name, "_cnt"},   {32'd0, fetch_cnt},   {32'd0, exp_cnt});
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ready = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    target = 64'd0;
    halt = 1'b0;
    #1;
    $display("[TB] reset and boot");
    checkLiteral("reset", 64'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkLiteral("boot", 64'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("first_fetch", 64'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("seq4", 64'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("seq8", 64'h8, 1'b1, 1'b0, 1'b0, 32'd2);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("seqC", 64'hC, 1'b1, 1'b0, 1'b0, 32'd3);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("four_accepts", 64'h10, 1'b1, 1'b0, 1'b0, 32'd4);

    $display("[TB] backpressure and stall");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 64'd0, 0);
      checkLiteral("backpressure", 64'h10, 1'b1, 1'b0, 1'b0, 32'd4);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 64'd0, 0);
      checkLiteral("stall", 64'h10, 1'b1, 1'b0, 1'b0, 32'd4);
    end
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("release", 64'h14, 1'b1, 1'b0, 1'b0, 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("at_20", 64'h20, 1'b1, 1'b0, 1'b0, 32'd8);

    $display("[TB] redirect over stall");
    applyStimulus(1, 1, 1, 64'h1000, 0);
    checkLiteral("redirect_bubble", 64'h1000, 1'b0, 1'b1, 1'b0, 32'd8);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("redirect_fetch", 64'h1000, 1'b1, 1'b0, 1'b0, 32'd8);

    $display("[TB] misaligned target");
    applyStimulus(1, 0, 1, 64'h1002, 0);
    checkLiteral("misaligned", 64'h200, 1'b0, 1'b1, 1'b1, 32'd8);
    applyStimulus(0, 0, 0, 64'd0, 0);
    checkLiteral("after_fault", 64'h200, 1'b1, 1'b0, 1'b0, 32'd8);

    $display("[TB] back-to-back redirects");
    applyStimulus(1, 0, 1, 64'h40, 0);
    checkLiteral("b2b_first", 64'h40, 1'b0, 1'b1, 1'b0, 32'd8);
    applyStimulus(1, 0, 1, 64'h80, 0);
    checkLiteral("b2b_second", 64'h80, 1'b0, 1'b1, 1'b0, 32'd8);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("b2b_fetch", 64'h80, 1'b1, 1'b0, 1'b0, 32'd8);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("b2b_resume", 64'h84, 1'b1, 1'b0, 1'b0, 32'd9);

    $display("[TB] halt and wrap");
    applyStimulus(0, 0, 1, 64'h30, 0);
    applyStimulus(1, 0, 0, 64'd0, 1);
    checkLiteral("halt_enter", 64'h30, 1'b0, 1'b0, 1'b0, 32'd9);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 0, 64'd0, 0);
      checkLiteral("halted", 64'h30, 1'b0, 1'b0, 1'b0, 32'd9);
    end
    applyStimulus(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    checkLiteral("wrap_bubble", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'd9);
    checkOutput("wrap_plus4", pc_plus4, 64'h0);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("wrap_fetch", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd9);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("wrapped", 64'h0, 1'b1, 1'b0, 1'b0, 32'd10);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("post_wrap", 64'h4, 1'b1, 1'b0, 1'b0, 32'd11);

    $display("[TB] asynchronous reset mid-halt");
    applyStimulus(1, 0, 0, 64'd0, 1);
    applyStimulus(0, 0, 0, 64'd0, 0);
    checkLiteral("halt_again", 64'h4, 1'b0, 1'b0, 1'b0, 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    checkLiteral("async_reset", RESET_VECTOR, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("reboot", 64'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 0, 0, 64'd0, 0);
    checkLiteral("reboot_seq", 64'h4, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
